tcp_rx_cmd: RTL and testbench

TCP_RX_CMD -- requirements
Module: tcp_rx_cmd

---
 rtl/tcp_cmd_pkg.sv | 23 ++
 rtl/rx_byte_fifo.sv | 46 ++++
 rtl/tcp_rx_cmd.sv | 139 +++++++++++++
 tb/tb_tcp_rx_cmd.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_cmd_pkg.sv
// tcp_cmd_pkg: parser state encoding, frame header and command table shared by the command receiver.
package tcp_cmd_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_CMD,
    ST_HDR_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_EXEC
  } state_t;
  localparam logic [7:0] HDR         = 8'hA5;
  localparam logic [7:0] CMD_LED_SET = 8'h01;
  localparam logic [7:0] CMD_LED_XOR = 8'h02;
  localparam logic [7:0] CMD_LED_CLR = 8'h03;
  localparam logic [7:0] LEN_LED_SET = 8'd1;
  localparam logic [7:0] LEN_LED_XOR = 8'd1;
  localparam logic [7:0] LEN_LED_CLR = 8'd0;
  function automatic logic cmd_ok(input logic [7:0] cmd, input logic [7:0] len);
    return (cmd == CMD_LED_SET && len == LEN_LED_SET) ||
           (cmd == CMD_LED_XOR && len == LEN_LED_XOR) ||
           (cmd == CMD_LED_CLR && len == LEN_LED_CLR);
  endfunction
endpackage

// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo: first-word-fall-through byte FIFO with occupancy count and drop strobe.
module rx_byte_fifo #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          drop
);
  logic [7:0]    mem_q [2**AW];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, do_push, do_pop;
  always_comb begin
    full     = count_q[AW];
    empty    = count_q == '0;
    do_pop   = pop & ~empty;
    // a full FIFO still accepts a byte when one leaves in the same cycle
    do_push  = wr & (~full | do_pop);
    drop     = wr & ~do_push;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= din;
  end
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/tcp_rx_cmd.sv
// tcp_rx_cmd: buffers SiTCP RX bytes, parses A5/CMD/LEN/payload/CSUM frames and executes LED commands.
module tcp_rx_cmd
  import tcp_cmd_pkg::*;
#(
  parameter int FIFO_AW = 8,
  parameter int MAX_PLD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_wr,
  input  logic [7:0]  rx_data,
  input  logic        rx_hold,
  output logic [15:0] rx_wc,
  output logic [7:0]  led,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        ovf
);
  state_t          state_q, state_d;
  logic [7:0]      fifo_dout;
  logic            fifo_empty, fifo_drop, pop, accept;
  logic [FIFO_AW:0] fifo_count;
  logic [7:0]      cmd_q, cmd_d, len_q, len_d, idx_q, idx_d, csum_q, csum_d;
  logic [7:0]      led_q, led_d, cmd_code_q, cmd_code_d, err_q, err_d;
  logic            cmd_valid_q, cmd_valid_d, frame_err_q, frame_err_d, ovf_q, ovf_d;
  logic [7:0]      pld_q [MAX_PLD];
  logic [7:0]      pld_d [MAX_PLD];

  rx_byte_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (rx_wr),
    .din   (rx_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count),
    .drop  (fifo_drop)
  );

  assign pop = ~fifo_empty & ~rx_hold & (state_q != ST_EXEC);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_EXEC) state_d = ST_IDLE;
    else if (pop) begin
      unique case (state_q)
        ST_IDLE:    state_d = fifo_dout == HDR ? ST_HDR_CMD : ST_IDLE;
        ST_HDR_CMD: state_d = ST_HDR_LEN;
        ST_HDR_LEN: state_d = fifo_dout != 8'd0 ? ST_PAYLOAD : ST_CSUM;
        ST_PAYLOAD: state_d = idx_q == len_q - 8'd1 ? ST_CSUM : ST_PAYLOAD;
        ST_CSUM:    state_d = ST_EXEC;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Verdict is registered on the CSUM pop so results are visible throughout EXEC.
  always_comb begin
    cmd_d       = cmd_q;
    len_d       = len_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    pld_d       = pld_q;
    led_d       = led_q;
    cmd_code_d  = cmd_code_q;
    err_d       = err_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;
    ovf_d       = ovf_q | fifo_drop;
    accept      = fifo_dout == csum_q && len_q <= 8'(MAX_PLD) && cmd_ok(cmd_q, len_q);
    if (pop && state_q == ST_HDR_CMD) begin
      cmd_d  = fifo_dout;
      csum_d = fifo_dout;
    end
    if (pop && state_q == ST_HDR_LEN) begin
      len_d  = fifo_dout;
      csum_d = csum_q ^ fifo_dout;
      idx_d  = 8'd0;
    end
    if (pop && state_q == ST_PAYLOAD) begin
      csum_d = csum_q ^ fifo_dout;
      idx_d  = idx_q + 8'd1;
      for (int i = 0; i < MAX_PLD; i++) if (idx_q == 8'(i)) pld_d[i] = fifo_dout;
    end
    if (pop && state_q == ST_CSUM) begin
      cmd_valid_d = accept;
      frame_err_d = ~accept;
      cmd_code_d  = accept ? cmd_q : cmd_code_q;
      led_d       = !accept                ? led_q :
                    cmd_q == CMD_LED_SET   ? pld_q[0] :
                    cmd_q == CMD_LED_XOR   ? led_q ^ pld_q[0] : 8'h00;
      err_d       = accept || err_q == 8'hFF ? err_q : err_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      csum_q      <= '0;
      led_q       <= '0;
      cmd_code_q  <= '0;
      err_q       <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
      for (int i = 0; i < MAX_PLD; i++) pld_q[i] <= '0;
    end else begin
      cmd_q       <= cmd_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      csum_q      <= csum_d;
      led_q       <= led_d;
      cmd_code_q  <= cmd_code_d;
      err_q       <= err_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
      pld_q       <= pld_d;
    end
  end

  assign rx_wc     = {{(16-FIFO_AW-1){1'b1}}, fifo_count};
  assign led       = led_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_code  = cmd_code_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_tcp_rx_cmd.sv
// tb_tcp_rx_cmd: scenario tasks plus randomized frames checked against a frame-level reference model.
module tb_tcp_rx_cmd;
  logic        clk = 1'b0;
  logic        rst, rx_wr, rx_hold;
  logic [7:0]  rx_data;
  logic [15:0] rx_wc;
  logic [7:0]  led, cmd_code, err_cnt;
  logic        cmd_valid, frame_err, ovf;

  tcp_rx_cmd #(.FIFO_AW(8), .MAX_PLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_wr     (rx_wr),
    .rx_data   (rx_data),
    .rx_hold   (rx_hold),
    .rx_wc     (rx_wc),
    .led       (led),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .frame_err (frame_err),
    .err_cnt   (err_cnt),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int  compared = 0, mismatched = 0;
  int  cv_cnt = 0, fe_cnt = 0;
  time last_cv_t = 0;
  logic [7:0] m_led = 0, m_err = 0, m_code = 0;
  bit  hold_rand = 0;

  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin cv_cnt++; last_cv_t = $time; end
    if (frame_err === 1'b1) fe_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_wr   = 1'b1;
    rx_data = b;
    rx_hold = hold_rand && ($urandom_range(0, 3) == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); rx_wr = 1'b0; end
  endtask

  task automatic drain;
    int n = 0;
    @(negedge clk);
    rx_wr = 1'b0;
    rx_hold = 1'b0;
    while (rx_wc !== 16'hFE00 && n < 2000) begin @(negedge clk); n++; end
    compared++;
    if (n >= 2000) begin mismatched++; $display("FAIL drain_timeout rx_wc=%h required FE00", rx_wc); end
    repeat (3) @(negedge clk);
  endtask

  // Sends one frame (optionally preceded by a non-header junk byte) and advances the model.
  task automatic send_frame(input logic [7:0] cmd, input int len, input logic [7:0] p0,
                            input logic [7:0] csum_xor, input bit junk, output time t_hdr);
    logic [7:0] pl[$];
    logic [7:0] cs, j;
    bit ok;
    pl = {};
    for (int i = 0; i < len; i++) pl.push_back(i == 0 ? p0 : 8'($urandom));
    cs = cmd ^ 8'(len);
    foreach (pl[i]) cs ^= pl[i];
    if (junk) begin
      j = 8'($urandom);
      send_byte(j == 8'hA5 ? 8'h5A : j);
    end
    send_byte(8'hA5);
    t_hdr = $time;
    send_byte(cmd);
    send_byte(8'(len));
    foreach (pl[i]) send_byte(pl[i]);
    send_byte(cs ^ csum_xor);
    ok = csum_xor == 0 && len <= 4 &&
         (((cmd == 8'h01 || cmd == 8'h02) && len == 1) || (cmd == 8'h03 && len == 0));
    if (ok) begin
      m_code = cmd;
      m_led  = cmd == 8'h01 ? p0 : cmd == 8'h02 ? (m_led ^ p0) : 8'h00;
    end else if (m_err != 8'hFF) m_err++;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; rx_wr = 1'b0; rx_hold = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_led = 0; m_err = 0; m_code = 0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_wr = 1'b1; rx_data = 8'hA5; rx_hold = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (rx_wc !== 16'hFE00) begin mismatched++; $display("FAIL reset_rx_wc got %h want FE00", rx_wc); end
    compared++;
    if ({led, cmd_code, err_cnt} !== 24'h0) begin mismatched++; $display("FAIL reset_regs got led=%h code=%h err=%h want 0", led, cmd_code, err_cnt); end
    compared++;
    if ({ovf, cmd_valid, frame_err} !== 3'b000) begin mismatched++; $display("FAIL reset_flags got %b want 000", {ovf, cmd_valid, frame_err}); end
    rst = 1'b0; rx_wr = 1'b0;
    idle(2);
    compared++;
    if (rx_wc !== 16'hFE00) begin mismatched++; $display("FAIL reset_wr_ignored got %h want FE00", rx_wc); end
  endtask

  task automatic test_led_set;
    int cv0 = cv_cnt;
    time t0;
    int lat;
    send_frame(8'h01, 1, 8'h3C, 8'h00, 0, t0);
    drain();
    lat = int'((last_cv_t - t0) / 10);
    compared++;
    if (cv_cnt - cv0 != 1) begin mismatched++; $display("FAIL set_pulses got %0d want 1", cv_cnt - cv0); end
    compared++;
    if (led !== 8'h3C || cmd_code !== 8'h01 || err_cnt !== 8'h00) begin mismatched++; $display("FAIL set_result got led=%h code=%h err=%h want 3C 01 00", led, cmd_code, err_cnt); end
    compared++;
    if (lat < 6 || lat > 8) begin mismatched++; $display("FAIL set_latency got %0d cycles want 6..8", lat); end
  endtask

  task automatic test_discard_xor;
    int cv0 = cv_cnt, fe0 = fe_cnt;
    time t0;
    send_byte(8'h00);
    send_frame(8'h02, 1, 8'hFF, 8'h00, 0, t0);
    drain();
    compared++;
    if (cv_cnt - cv0 != 1 || fe_cnt != fe0) begin mismatched++; $display("FAIL xor_pulses got cv=%0d fe=%0d want 1 0", cv_cnt - cv0, fe_cnt - fe0); end
    compared++;
    if (led !== 8'hC3 || cmd_code !== 8'h02) begin mismatched++; $display("FAIL xor_result got led=%h code=%h want C3 02", led, cmd_code); end
  endtask

  task automatic test_bad_csum;
    int cv0 = cv_cnt, fe0 = fe_cnt;
    time t0;
    send_frame(8'h01, 1, 8'h3C, 8'h3C, 0, t0);
    drain();
    compared++;
    if (fe_cnt - fe0 != 1 || cv_cnt != cv0) begin mismatched++; $display("FAIL bad_pulses got fe=%0d cv=%0d want 1 0", fe_cnt - fe0, cv_cnt - cv0); end
    compared++;
    if (err_cnt !== 8'h01 || led !== 8'hC3 || cmd_code !== 8'h02) begin mismatched++; $display("FAIL bad_result got err=%h led=%h code=%h want 01 C3 02", err_cnt, led, cmd_code); end
    send_frame(8'h03, 0, 8'h00, 8'h00, 0, t0);
    drain();
    compared++;
    if (led !== 8'h00 || cmd_code !== 8'h03) begin mismatched++; $display("FAIL clr_result got led=%h code=%h want 00 03", led, cmd_code); end
  endtask

  task automatic test_overflow;
    int cv0 = cv_cnt, fe0 = fe_cnt;
    @(negedge clk);
    rx_hold = 1'b1;
    for (int i = 0; i < 257; i++) begin @(negedge clk); rx_wr = 1'b1; rx_data = 8'h11; end
    idle(1);
    compared++;
    if (rx_wc !== 16'hFF00) begin mismatched++; $display("FAIL ovf_full got %h want FF00", rx_wc); end
    compared++;
    if (ovf !== 1'b1) begin mismatched++; $display("FAIL ovf_flag got %b want 1", ovf); end
    rx_hold = 1'b0;
    repeat (255) @(negedge clk);
    compared++;
    if (rx_wc !== 16'hFE01) begin mismatched++; $display("FAIL ovf_drain255 got %h want FE01", rx_wc); end
    @(negedge clk);
    compared++;
    if (rx_wc !== 16'hFE00) begin mismatched++; $display("FAIL ovf_drain256 got %h want FE00", rx_wc); end
    idle(3);
    compared++;
    if (cv_cnt != cv0 || fe_cnt != fe0 || err_cnt !== m_err || led !== m_led) begin mismatched++; $display("FAIL ovf_junk got cv=%0d fe=%0d err=%h led=%h want 0 0 %h %h", cv_cnt - cv0, fe_cnt - fe0, err_cnt, led, m_err, m_led); end
  endtask

  task automatic test_rst_mid;
    int fe0;
    time t0;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    do_reset();
    fe0 = fe_cnt;
    compared++;
    if (ovf !== 1'b0 || rx_wc !== 16'hFE00) begin mismatched++; $display("FAIL rstmid_clear got ovf=%b wc=%h want 0 FE00", ovf, rx_wc); end
    send_frame(8'h01, 1, 8'h55, 8'h00, 0, t0);
    drain();
    compared++;
    if (led !== 8'h55 || err_cnt !== 8'h00 || fe_cnt != fe0 || cmd_code !== 8'h01) begin mismatched++; $display("FAIL rstmid_result got led=%h err=%h fe=%0d code=%h want 55 00 0 01", led, err_cnt, fe_cnt - fe0, cmd_code); end
  endtask

  task automatic test_saturate;
    int cv0 = cv_cnt, fe0 = fe_cnt;
    time t0;
    for (int f = 0; f < 256; f++) begin
      send_frame(8'h01, 5, 8'h77, 8'h00, 0, t0);
      idle(2);
    end
    drain();
    compared++;
    if (err_cnt !== 8'hFF || err_cnt !== m_err) begin mismatched++; $display("FAIL sat_err got %h want FF", err_cnt); end
    compared++;
    if (fe_cnt - fe0 != 256 || cv_cnt != cv0) begin mismatched++; $display("FAIL sat_pulses got fe=%0d cv=%0d want 256 0", fe_cnt - fe0, cv_cnt - cv0); end
    compared++;
    if (led !== m_led) begin mismatched++; $display("FAIL sat_led got %h want %h", led, m_led); end
  endtask

  task automatic test_random;
    time t0;
    int cv0, fe0;
    logic [7:0] e_err, cmd;
    bit ok;
    do_reset();
    hold_rand = 1;
    for (int f = 0; f < 60; f++) begin
      cv0 = cv_cnt; fe0 = fe_cnt; e_err = m_err;
      cmd = 8'($urandom_range(0, 4));
      send_frame(cmd, $urandom_range(0, 6), 8'($urandom),
                 $urandom_range(0, 3) == 0 ? 8'($urandom_range(1, 255)) : 8'h00,
                 $urandom_range(0, 1) == 1, t0);
      drain();
      ok = m_err == e_err && !(e_err == 8'hFF);
      compared++;
      if (led !== m_led || cmd_code !== m_code || err_cnt !== m_err) begin mismatched++; $display("FAIL rand%0d_regs got led=%h code=%h err=%h want %h %h %h", f, led, cmd_code, err_cnt, m_led, m_code, m_err); end
      compared++;
      if (cv_cnt - cv0 + fe_cnt - fe0 != 1 || (ok && cv_cnt - cv0 != 1)) begin mismatched++; $display("FAIL rand%0d_pulses got cv=%0d fe=%0d want one pulse", f, cv_cnt - cv0, fe_cnt - fe0); end
    end
    hold_rand = 0;
  endtask

  initial begin
    test_reset();
    test_led_set();
    test_discard_xor();
    test_bad_csum();
    test_overflow();
    test_rst_mid();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
